// File: rtl/alu_arbiter_if.sv
// Requester/response bundle for alu_arbiter: two operand ports in, one ID-tagged response out.
// The master side is the requester pair, the slave side is the arbiter.
interface alu_arbiter_if #(parameter int DW = 32);
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [DW-1:0] req_A0, req_B0;
  logic [3:0]    req_op0;
  logic [DW-1:0] req_A1, req_B1;
  logic [3:0]    req_op1;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_id;
  logic [DW-1:0] rsp_dout;
  logic          rsp_zero;
  logic          rsp_err;

  modport master (
    output req_valid, req_A0, req_B0, req_op0, req_A1, req_B1, req_op1, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_dout, rsp_zero, rsp_err
  );

  modport slave (
    input  req_valid, req_A0, req_B0, req_op0, req_A1, req_B1, req_op1, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_dout, rsp_zero, rsp_err
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters, one op in flight.
// Optional ALU_ARB_OPCHECK_EN: illegal opcodes are masked to 0000 and reported via rsp_err.
module alu_arbiter #(
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  alu_arbiter_if.slave  bus,
  output logic [DW-1:0] alu_A,
  output logic [DW-1:0] alu_B,
  output logic [3:0]    alu_op,
  input  logic [DW-1:0] alu_dout,
  input  logic          alu_zero,
  output logic          busy,
  output logic [CW-1:0] op_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [3:0]    op;
  } req_t;

  logic [1:0]    state;
  logic          last_grant;
  logic          win;
  logic          fire;
  logic          sel_bad;
  logic          bad_q;
  logic [3:0]    sel_op;
  req_t [1:0]    req_in;
  req_t          sel;
  logic          rsp_id_q;
  logic [DW-1:0] rsp_dout_q;
  logic          rsp_zero_q;

  assign req_in[0] = {bus.req_A0, bus.req_B0, bus.req_op0};
  assign req_in[1] = {bus.req_A1, bus.req_B1, bus.req_op1};

  // On a tie the requester that did not win last time goes; otherwise the lone valid one.
  always_comb begin
    win = bus.req_valid[1];
    if (&bus.req_valid) win = ~last_grant;
  end

  assign sel  = req_in[win];
  assign fire = |(bus.req_valid & bus.req_ready);

  assign bus.req_ready = (state == IDLE && |bus.req_valid && !rst) ?
                         (win ? 2'b10 : 2'b01) : 2'b00;

`ifdef ALU_ARB_OPCHECK_EN
  logic err_q;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0110,
      4'b0111, 4'b1100, 4'b1101: op_legal = 1'b1;
      default:                   op_legal = 1'b0;
    endcase
  endfunction

  assign sel_bad     = ~op_legal(sel.op);
  assign bus.rsp_err = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                err_q <= 1'b0;
    else if (state == EXEC) err_q <= bad_q;
  end
`else
  assign sel_bad     = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  // Illegal opcodes never reach the ALU; it sees a harmless AND instead.
  assign sel_op = sel_bad ? 4'b0000 : sel.op;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      alu_A      <= '0;
      alu_B      <= '0;
      alu_op     <= 4'b0000;
      bad_q      <= 1'b0;
      rsp_id_q   <= 1'b0;
      rsp_dout_q <= '0;
      rsp_zero_q <= 1'b0;
      op_count   <= '0;
    end else begin
      case (state)
        IDLE: if (fire) begin
          alu_A      <= sel.a;
          alu_B      <= sel.b;
          alu_op     <= sel_op;
          bad_q      <= sel_bad;
          rsp_id_q   <= win;
          last_grant <= win;
          state      <= EXEC;
        end
        EXEC: begin
          rsp_dout_q <= bad_q ? '0 : alu_dout;
          rsp_zero_q <= bad_q | alu_zero;
          state      <= RESP;
        end
        RESP: if (bus.rsp_ready) begin
          op_count <= op_count + 1'b1;
          alu_A    <= '0;
          alu_B    <= '0;
          alu_op   <= 4'b0000;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_dout  = rsp_dout_q;
  assign bus.rsp_zero  = rsp_zero_q;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a transaction-level model predicts every output each cycle,
// and literal expectations from hand-worked cases pin the model.
module tb_alu_arbiter;
  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] alu_A, alu_B, alu_dout;
  logic [3:0]    alu_op;
  logic          alu_zero, busy;
  logic [CW-1:0] op_count;

  alu_arbiter_if #(.DW(DW)) bus ();

  alu_arbiter #(.DW(DW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op),
    .alu_dout(alu_dout), .alu_zero(alu_zero),
    .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
    case (op)
      4'b0000: alu_ref = a & b;
      4'b0001: alu_ref = a | b;
      4'b0010: alu_ref = a + b;
      4'b0110: alu_ref = a - b;
      4'b0111: alu_ref = (a < b) ? 32'd1 : 32'd0;
      4'b1100: alu_ref = ~(a | b);
      4'b1101: alu_ref = a ^ b;
      default: alu_ref = 32'd0;
    endcase
  endfunction

  function automatic bit legal(input logic [3:0] op);
    legal = (op == 4'b0000 || op == 4'b0001 || op == 4'b0010 || op == 4'b0110 ||
             op == 4'b0111 || op == 4'b1100 || op == 4'b1101);
  endfunction

  // Stand-in combinational ALU
  always_comb begin
    alu_dout = alu_ref(alu_A, alu_B, alu_op);
    alu_zero = (alu_dout == 32'd0);
  end

  int n_run = 0;
  int n_fail = 0;

  // Model: phase = cycles into the current operation (0 none, 1 operands on ALU, 2 response out)
  int          m_phase;
  bit          m_last;
  int          m_count;
  int          m_done = 0;
  logic [1:0]  m_hs;
  logic        m_id;
  logic [31:0] m_a, m_b, m_dout;
  logic [3:0]  m_op;
  logic        m_zero, m_err;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic pick(input logic [1:0] v, input bit last);
    pick = (v == 2'b11) ? ~last : v[1];
  endfunction

  task automatic model_step();
    logic [1:0]  v;
    logic        g;
    logic [31:0] a, b;
    logic [3:0]  op;
    v    = bus.req_valid;
    m_hs = 2'b00;
    if (rst) begin
      m_phase = 0; m_last = 1'b1; m_count = 0;
      return;
    end
    case (m_phase)
      0: if (v != 2'b00) begin
        g      = pick(v, m_last);
        m_last = g;
        m_id   = g;
        m_hs   = g ? 2'b10 : 2'b01;
        a  = g ? bus.req_A1 : bus.req_A0;
        b  = g ? bus.req_B1 : bus.req_B0;
        op = g ? bus.req_op1 : bus.req_op0;
        m_a = a; m_b = b;
`ifdef ALU_ARB_OPCHECK_EN
        if (!legal(op)) begin
          m_op = 4'b0000; m_dout = 32'd0; m_zero = 1'b1; m_err = 1'b1;
        end else begin
          m_op = op; m_dout = alu_ref(a, b, op); m_zero = (m_dout == 0); m_err = 1'b0;
        end
`else
        m_op = op; m_dout = alu_ref(a, b, op); m_zero = (m_dout == 0); m_err = 1'b0;
`endif
        m_phase = 1;
      end
      1: m_phase = 2;
      default: if (bus.rsp_ready) begin
        m_count = (m_count + 1) % (1 << CW);
        m_done++;
        m_phase = 0;
      end
    endcase
  endtask

  task automatic compare();
    logic [1:0] er;
    if (rst) begin
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_rsp_id",    bus.rsp_id, 0);
      chk("rst_rsp_dout",  bus.rsp_dout, 0);
      chk("rst_rsp_zero",  bus.rsp_zero, 0);
      chk("rst_rsp_err",   bus.rsp_err, 0);
      chk("rst_alu",       {alu_A, alu_B, alu_op}, 0);
      chk("rst_busy",      busy, 0);
      chk("rst_op_count",  op_count, 0);
      return;
    end
    er = 2'b00;
    if (m_phase == 0 && bus.req_valid != 2'b00)
      er = pick(bus.req_valid, m_last) ? 2'b10 : 2'b01;
    chk("req_ready", bus.req_ready, er);
    chk("rsp_valid", bus.rsp_valid, m_phase == 2);
    chk("busy", busy, m_phase != 0);
    chk("op_count", op_count, m_count);
    if (m_phase != 0) begin
      chk("alu_A", alu_A, m_a);
      chk("alu_B", alu_B, m_b);
      chk("alu_op", alu_op, m_op);
    end else begin
      chk("alu_idle", {alu_A, alu_B, alu_op}, 0);
    end
    if (m_phase == 2) begin
      chk("rsp_id", bus.rsp_id, m_id);
      chk("rsp_dout", bus.rsp_dout, m_dout);
      chk("rsp_zero", bus.rsp_zero, m_zero);
      chk("rsp_err", bus.rsp_err, m_err);
    end
  endtask

  // One clock: model samples at the edge, outputs checked mid-cycle, granted requesters drop valid.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
    bus.req_valid = bus.req_valid & ~m_hs;
  endtask

  task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op);
    if (id == 0) begin
      bus.req_A0 = a; bus.req_B0 = b; bus.req_op0 = op;
    end else begin
      bus.req_A1 = a; bus.req_B1 = b; bus.req_op1 = op;
    end
    bus.req_valid[id] = 1'b1;
  endtask

  task automatic wait_rsp();
    int k;
    k = 0;
    while (!bus.rsp_valid && k < 20) begin
      tick();
      k++;
    end
    if (!bus.rsp_valid) chk("rsp_timeout", bus.rsp_valid, 1);
  endtask

  task automatic run_op(input int id, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op);
    int d0, k;
    set_req(id, a, b, op);
    d0 = m_done;
    k  = 0;
    while (m_done == d0 && k < 30) begin
      tick();
      k++;
    end
    chk("op_done", m_done != d0, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = 2'b00;
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic [3:0] ops [7] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1101};

  initial begin
    rst = 1'b1;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b1;
    bus.req_A0 = '0; bus.req_B0 = '0; bus.req_op0 = '0;
    bus.req_A1 = '0; bus.req_B1 = '0; bus.req_op1 = '0;
    do_reset();

    // Single request: 5 + 3
    set_req(0, 32'd5, 32'd3, 4'b0010);
    tick();
    chk("s1_alu_A", alu_A, 32'd5);
    chk("s1_alu_op", alu_op, 4'b0010);
    tick();
    chk("s1_rsp_valid", bus.rsp_valid, 1);
    chk("s1_rsp_dout", bus.rsp_dout, 32'd8);
    chk("s1_rsp_zero", bus.rsp_zero, 0);
    chk("s1_rsp_id", bus.rsp_id, 0);
    tick();
    chk("s1_op_count", op_count, 1);

    // Tie from reset: requester 0 first, then 1, then 0 again
    do_reset();
    set_req(0, 32'd7, 32'd7, 4'b0110);
    set_req(1, 32'hF0, 32'h0F, 4'b0001);
    wait_rsp();
    chk("tie1_id", bus.rsp_id, 0);
    chk("tie1_dout", bus.rsp_dout, 0);
    chk("tie1_zero", bus.rsp_zero, 1);
    tick();
    wait_rsp();
    chk("tie2_id", bus.rsp_id, 1);
    chk("tie2_dout", bus.rsp_dout, 32'hFF);
    tick();
    set_req(0, 32'hC, 32'hA, 4'b0000);
    set_req(1, 32'hC, 32'hA, 4'b1101);
    wait_rsp();
    chk("tie3_id", bus.rsp_id, 0);
    chk("tie3_dout", bus.rsp_dout, 32'h8);
    tick();
    wait_rsp();
    chk("tie4_id", bus.rsp_id, 1);
    chk("tie4_dout", bus.rsp_dout, 32'h6);
    tick();

    // Backpressure: response held for 10 cycles
    bus.rsp_ready = 1'b0;
    set_req(0, 32'd100, 32'd23, 4'b0010);
    wait_rsp();
    for (int i = 0; i < 10; i++) begin
      if (i == 3) set_req(1, 32'd1, 32'd1, 4'b0010);
      tick();
    end
    chk("bp_dout", bus.rsp_dout, 32'd123);
    chk("bp_alu_A", alu_A, 32'd100);
    chk("bp_req_ready", bus.req_ready, 0);
    bus.rsp_ready = 1'b1;
    tick();
    chk("bp_idle", busy, 0);
    wait_rsp();
    chk("bp_held_id", bus.rsp_id, 1);
    tick();

    // Reset while in EXEC drops the operation
    set_req(1, 32'h55, 32'hAA, 4'b1101);
    tick();
    chk("mid_busy_pre", busy, 1);
    rst = 1'b1;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_rsp_valid", bus.rsp_valid, 0);
    chk("mid_alu", {alu_A, alu_B, alu_op}, 0);
    chk("mid_op_count", op_count, 0);
    tick();
    tick();
    rst = 1'b0;
    run_op(0, 32'd3, 32'd5, 4'b0111);

    // Undefined opcode
    bus.rsp_ready = 1'b0;
    set_req(1, 32'd1, 32'd2, 4'b1111);
    wait_rsp();
`ifdef ALU_ARB_OPCHECK_EN
    chk("bad_err", bus.rsp_err, 1);
`else
    chk("bad_err", bus.rsp_err, 0);
`endif
    chk("bad_dout", bus.rsp_dout, 0);
    chk("bad_zero", bus.rsp_zero, 1);
    bus.rsp_ready = 1'b1;
    tick();

    // op_count wraps after 16 completions with CW=4
    do_reset();
    for (int i = 0; i < 16; i++) begin
      run_op(i % 2, 32'h1357_9BDF * (i + 1), 32'h0246_8ACE + i, ops[i % 7]);
      if (i == 14) chk("wrap_15", op_count, 15);
    end
    chk("wrap_0", op_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single-cycle 32-bit ALU between two independent requesters, such as the execute stage and a debug/test port. It accepts one operation at a time through a valid/ready handshake and arbitrates round-robin on ties. It drives the ALU operands and opcode from registers, captures the ALU result and zero flag, and returns them on a shared response channel tagged with the requester ID. It sits between the requesters and the combinational ALU and owns the ALU's input pins.

## Interface
- DW, 32, operand/result width; must match the ALU.
- CW, 16, width of completed-operation counter.

- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  2  per-requester request valid; bit i belongs to requester i.
- req_ready  output  2  per-requester accept.
- req_A0, req_B0  input  DW each  requester 0 operands.
- req_op0  input  4  requester 0 opcode.
- req_A1, req_B1  input  DW each  requester 1 operands.
- req_op1  input  4  requester 1 opcode.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response accept.
- rsp_id  output  1  requester that issued the operation.
- rsp_dout  output  DW  ALU result.
- rsp_zero  output  1  ALU zero flag.
- rsp_err  output  1  illegal opcode; driven only when ALU_ARB_OPCHECK_EN is defined, otherwise tied 0.
- alu_A, alu_B  output  DW each  to ALU din_A/din_B; registered.
- alu_op  output  4  to ALU op; registered.
- alu_dout  input  DW  from ALU.
- alu_zero  input  1  from ALU.
- busy  output  1  high in any state other than IDLE.
- op_count  output  CW  completed responses; wraps.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE:**
  - Grant is combinational. If only one requester is valid, it wins.
  - If both are valid, the requester not equal to last_grant wins.
  - req_ready is one-hot on the winner and 0 when neither is valid.
  - On handshake: latch A, B and op into alu_A/alu_B/alu_op, latch the ID, set last_grant to the ID, go to EXEC.
- **EXEC:** req_ready=0. At the end of the cycle, capture alu_dout into rsp_dout and alu_zero into rsp_zero, then go to RESP.
- **RESP:**
  - rsp_valid=1 and req_ready=0.
  - rsp_* hold stable until rsp_ready.
  - On rsp_valid&&rsp_ready: op_count increments (wraps 2^CW-1 → 0), alu_A/B/op return to 0, go to IDLE.
- A request held during EXEC/RESP is not lost. It is evaluated in the first IDLE cycle, where round-robin guarantees the other requester wins if both are pending.
- The ALU is never driven with a new operation while a result is unacknowledged.
- Valid opcodes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLTU, 1100 NOR, 1101 XOR.

## Timing
- Reset values:
  - state=IDLE, last_grant=1 (requester 0 wins the first tie).
  - req_ready=0, rsp_valid=0, rsp_id=0, rsp_dout=0, rsp_zero=0, rsp_err=0.
  - alu_A=0, alu_B=0, alu_op=0000, busy=0, op_count=0.
- Latency: handshake in cycle N, alu_* valid in N+1, rsp_valid asserted in N+2.
- Minimum issue interval is 3 cycles, reached with rsp_ready tied high.
- rsp_ready low stalls in RESP indefinitely. No timeout.
- Reset mid-operation clears all state. The in-flight operation is dropped with no response.
- rsp_ready asserted while rsp_valid=0 is ignored.

## Configuration
- **ALU_ARB_OPCHECK_EN defined:**
  - An opcode outside the valid list is still accepted and still takes 3 cycles.
  - alu_op is driven 0000.
  - The response carries rsp_err=1, rsp_dout=0, rsp_zero=1.
  - The response still counts in op_count.
- **Undefined:** every opcode is forwarded unchanged, whatever the ALU returns is reported, and rsp_err is constant 0.

## Test plan
- Reset then single request: requester 0 sends A=5, B=3, op=0010 in cycle 1 → alu_* valid in cycle 2; rsp_valid in cycle 3 with rsp_id=0, rsp_dout=8, rsp_zero=0; op_count=1 after accept.
- Tie and round-robin:
  - Both valid from reset: requester 0 gets SUB 7-7 and responds rsp_dout=0, rsp_zero=1.
  - Requester 1 then gets OR 0xF0|0x0F and responds 0xFF, id=1.
  - A third tie grants requester 0.
- Backpressure: rsp_ready low 10 cycles in RESP → rsp_* stable, req_ready=0, alu_* unchanged; accept on cycle 11 → IDLE next cycle.
- Reset mid-EXEC: assert rst during EXEC → all outputs at reset values immediately, no response, next request is served normally.
- Opcode 1111 with ALU_ARB_OPCHECK_EN → rsp_err=1, rsp_dout=0, rsp_zero=1; without the macro → rsp_err=0, rsp_dout equals the ALU output (0).
- op_count wrap: with CW=4, 16 completed ops → op_count returns to 0.
